// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IFU reads and EXU reads/writes
//
// Purpose: shares one single-port, one-cycle-latency memory between the
// instruction fetch unit (reads only) and the execute unit (reads and writes).
// The winning command is latched and driven to memory for exactly one cycle;
// read data is routed back to its owner with a one-cycle valid strobe.
// EXU has priority, bounded by a streak counter so that fetch is never starved.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifu_rd_req/addr -> ifu_gnt     IFU read request and grant pulse
//   ifu_rd_vld/data                IFU read return (data is 0 when not valid)
//   exu_rd_req/exu_wr_req/addr/wr_data -> exu_gnt
//                                  EXU request and grant pulse
//   exu_rd_vld/data                EXU read return (data is 0 when not valid)
//   mem_rd_req/wr_req/addr/wr_data memory command, non-zero only while issuing
//   mem_rd_data                    memory read data, valid the cycle after mem_rd_req
//   proto_err                      sticky: EXU asked for read and write together
module mem_port_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 12,
  parameter int MAX_EXU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_rd_req,
  input  logic [ADDR_W-1:0] ifu_rd_addr,
  output logic              ifu_gnt,
  output logic              ifu_rd_vld,
  output logic [DATA_W-1:0] ifu_rd_data,
  input  logic              exu_rd_req,
  input  logic              exu_wr_req,
  input  logic [ADDR_W-1:0] exu_addr,
  input  logic [DATA_W-1:0] exu_wr_data,
  output logic              exu_gnt,
  output logic              exu_rd_vld,
  output logic [DATA_W-1:0] exu_rd_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              proto_err
);

  localparam int SW = $clog2(MAX_EXU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_EXU_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              perr_q, perr_d;
  logic              cmd_wr_q, cmd_wr_d;    // latched op: 1 = write
  logic              cmd_exu_q, cmd_exu_d;  // latched owner: 1 = EXU
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

  logic exu_any;
  logic ifu_wins;
  logic arb_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      perr_q      <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_exu_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      perr_q      <= perr_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_exu_q   <= cmd_exu_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    perr_d      = perr_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_exu_d   = cmd_exu_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    arb_en      = 1'b0;
    exu_any     = exu_rd_req | exu_wr_req;
    // IFU only overrides a pending EXU request once the streak is exhausted.
    ifu_wins    = ifu_rd_req & (~exu_any | (streak_q == STREAK_MAX));

    case (state_q)
      S_IDLE, S_RESP: arb_en = 1'b1;
      // A write needs no response slot, so the port is free again right away.
      S_ISSUE: begin
        if (cmd_wr_q) arb_en = 1'b1;
        else          state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase

    if (arb_en) begin
      if (exu_rd_req && exu_wr_req) perr_d = 1'b1;

      if (ifu_rd_req || exu_any) begin
        state_d     = S_ISSUE;
        cmd_exu_d   = ~ifu_wins;
        // With both EXU strobes high the write is taken.
        cmd_wr_d    = ~ifu_wins & exu_wr_req;
        cmd_addr_d  = ifu_wins ? ifu_rd_addr : exu_addr;
        cmd_wdata_d = (~ifu_wins & exu_wr_req) ? exu_wr_data : '0;
      end else begin
        state_d = S_IDLE;
      end

      // Streak only counts EXU grants that made a waiting IFU wait longer.
      if (!ifu_rd_req || ifu_wins)      streak_d = '0;
      else if (streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
    end
  end

  logic in_issue;
  logic in_resp;

  assign in_issue    = (state_q == S_ISSUE);
  assign in_resp     = (state_q == S_RESP);

  assign mem_rd_req  = in_issue & ~cmd_wr_q;
  assign mem_wr_req  = in_issue & cmd_wr_q;
  assign mem_addr    = in_issue ? cmd_addr_q : '0;
  assign mem_wr_data = in_issue ? cmd_wdata_q : '0;

  assign ifu_gnt     = in_issue & ~cmd_exu_q;
  assign exu_gnt     = in_issue & cmd_exu_q;

  assign ifu_rd_vld  = in_resp & ~cmd_exu_q;
  assign exu_rd_vld  = in_resp & cmd_exu_q;
  assign ifu_rd_data = ifu_rd_vld ? mem_rd_data : '0;
  assign exu_rd_data = exu_rd_vld ? mem_rd_data : '0;

  assign proto_err   = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam logic [11:0] MKEY = 12'o7602;

  logic        clk;
  logic        rst;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic        ifu_gnt;
  logic        ifu_rd_vld;
  logic [11:0] ifu_rd_data;
  logic        exu_rd_req;
  logic        exu_wr_req;
  logic [11:0] exu_addr;
  logic [11:0] exu_wr_data;
  logic        exu_gnt;
  logic        exu_rd_vld;
  logic [11:0] exu_rd_data;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [11:0] mem_addr;
  logic [11:0] mem_wr_data;
  logic [11:0] mem_rd_data;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MAX_EXU_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_gnt(ifu_gnt),
    .ifu_rd_vld(ifu_rd_vld), .ifu_rd_data(ifu_rd_data),
    .exu_rd_req(exu_rd_req), .exu_wr_req(exu_wr_req), .exu_addr(exu_addr),
    .exu_wr_data(exu_wr_data), .exu_gnt(exu_gnt), .exu_rd_vld(exu_rd_vld),
    .exu_rd_data(exu_rd_data), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] memf(input logic [11:0] a);
    return a ^ MKEY;
  endfunction

  // Memory: one-cycle read latency, garbage on the data bus otherwise.
  always @(posedge clk)
    mem_rd_data <= mem_rd_req ? memf(mem_addr) : 12'($urandom);

  // Output vector: {ig, iv, idata, eg, ev, edata, mrd, mwr, maddr, mwdata, perr}
  function automatic logic [54:0] pack(input logic ig, input logic iv, input logic [11:0] id,
                                       input logic eg, input logic ev, input logic [11:0] ed,
                                       input logic mr, input logic mw, input logic [11:0] ma,
                                       input logic [11:0] md, input logic pe);
    return {ig, iv, id, eg, ev, ed, mr, mw, ma, md, pe};
  endfunction

  function automatic logic [54:0] e_none(input logic pe);
    return pack(0, 0, 12'd0, 0, 0, 12'd0, 0, 0, 12'd0, 12'd0, pe);
  endfunction
  function automatic logic [54:0] e_ifu_iss(input logic [11:0] a, input logic pe);
    return pack(1, 0, 12'd0, 0, 0, 12'd0, 1, 0, a, 12'd0, pe);
  endfunction
  function automatic logic [54:0] e_exu_rd(input logic [11:0] a, input logic pe);
    return pack(0, 0, 12'd0, 1, 0, 12'd0, 1, 0, a, 12'd0, pe);
  endfunction
  function automatic logic [54:0] e_exu_wr(input logic [11:0] a, input logic [11:0] d, input logic pe);
    return pack(0, 0, 12'd0, 1, 0, 12'd0, 0, 1, a, d, pe);
  endfunction
  function automatic logic [54:0] e_ifu_vld(input logic [11:0] d, input logic pe);
    return pack(0, 1, d, 0, 0, 12'd0, 0, 0, 12'd0, 12'd0, pe);
  endfunction
  function automatic logic [54:0] e_exu_vld(input logic [11:0] d, input logic pe);
    return pack(0, 0, 12'd0, 0, 1, d, 0, 0, 12'd0, 12'd0, pe);
  endfunction

  task automatic check(input string name, input logic [54:0] exp);
    logic [54:0] act;
    act = {ifu_gnt, ifu_rd_vld, ifu_rd_data, exu_gnt, exu_rd_vld, exu_rd_data,
           mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, proto_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Directed table: inputs held for one cycle, outputs expected in the next.
  typedef struct {
    string       name;
    logic        rst;
    logic        ifu_req;
    logic [11:0] ifu_addr;
    logic        exu_rd;
    logic        exu_wr;
    logic [11:0] exu_addr;
    logic [11:0] exu_wd;
    logic [54:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic iq, input logic [11:0] ia,
                     input logic er, input logic ew, input logic [11:0] ea,
                     input logic [11:0] ed, input logic [54:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.ifu_req = iq; v.ifu_addr = ia; v.exu_rd = er;
    v.exu_wr = ew; v.exu_addr = ea; v.exu_wd = ed; v.exp = e;
    vecs.push_back(v);
  endtask

  // Transaction-level reference: a command occupies the port for one cycle,
  // and a read additionally reserves the following cycle for its data.
  bit          m_iss_v, m_iss_wr, m_iss_exu;
  logic [11:0] m_iss_addr, m_iss_wd;
  bit          m_rsp_v, m_rsp_exu;
  logic [11:0] m_rsp_addr;
  int          m_streak;
  bit          m_perr;

  task automatic model_step();
    bit busy;
    bit exu_any;
    if (rst) begin
      m_iss_v = 0; m_rsp_v = 0; m_streak = 0; m_perr = 0;
      return;
    end
    busy       = m_iss_v && !m_iss_wr;
    m_rsp_v    = busy;
    m_rsp_exu  = m_iss_exu;
    m_rsp_addr = m_iss_addr;
    m_iss_v    = 0;
    if (!busy) begin
      exu_any = exu_rd_req || exu_wr_req;
      if (exu_rd_req && exu_wr_req) m_perr = 1;
      if (ifu_rd_req && (!exu_any || m_streak == MAXS)) begin
        m_iss_v = 1; m_iss_exu = 0; m_iss_wr = 0;
        m_iss_addr = ifu_rd_addr; m_iss_wd = 12'd0;
        m_streak = 0;
      end else if (exu_any) begin
        m_iss_v = 1; m_iss_exu = 1; m_iss_wr = exu_wr_req;
        m_iss_addr = exu_addr; m_iss_wd = exu_wr_req ? exu_wr_data : 12'd0;
        m_streak = ifu_rd_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  function automatic logic [54:0] model_exp();
    logic iv, ev;
    iv = m_rsp_v && !m_rsp_exu;
    ev = m_rsp_v && m_rsp_exu;
    return pack(m_iss_v && !m_iss_exu, iv, iv ? memf(m_rsp_addr) : 12'd0,
                m_iss_v && m_iss_exu, ev, ev ? memf(m_rsp_addr) : 12'd0,
                m_iss_v && !m_iss_wr, m_iss_v && m_iss_wr,
                m_iss_v ? m_iss_addr : 12'd0, m_iss_v ? m_iss_wd : 12'd0, m_perr);
  endfunction

  initial begin
    rst = 1; ifu_rd_req = 0; ifu_rd_addr = 0;
    exu_rd_req = 0; exu_wr_req = 0; exu_addr = 0; exu_wr_data = 0;
    repeat (3) @(negedge clk);

    add("reset",      1, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(0));
    // IFU alone
    add("ifu_gnt",    0, 1, 12'o0200, 0, 0, 12'o0000, 12'o0000, e_ifu_iss(12'o0200, 0));
    add("ifu_vld",    0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_ifu_vld(12'o7402, 0));
    add("ifu_idle",   0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(0));
    // Simultaneous reads: EXU first, IFU at the RESP arbitration
    add("sim_exu",    0, 1, 12'o0100, 1, 0, 12'o0300, 12'o0000, e_exu_rd(12'o0300, 0));
    add("sim_exuvld", 0, 1, 12'o0100, 0, 0, 12'o0000, 12'o0000, e_exu_vld(12'o7502, 0));
    add("sim_ifu",    0, 1, 12'o0100, 0, 0, 12'o0000, 12'o0000, e_ifu_iss(12'o0100, 0));
    add("sim_ifuvld", 0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_ifu_vld(12'o7702, 0));
    add("sim_idle",   0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(0));
    // Write followed immediately by a pending IFU read
    add("wr_issue",   0, 0, 12'o0000, 0, 1, 12'o1234, 12'o5555, e_exu_wr(12'o1234, 12'o5555, 0));
    add("wr_next",    0, 1, 12'o0400, 0, 0, 12'o0000, 12'o0000, e_ifu_iss(12'o0400, 0));
    add("wr_nextvld", 0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_ifu_vld(12'o7202, 0));
    add("wr_idle",    0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(0));
    // Read and write together: write wins, proto_err sticks
    add("perr_wr",    0, 0, 12'o0000, 1, 1, 12'o0055, 12'o1111, e_exu_wr(12'o0055, 12'o1111, 1));
    add("perr_hold1", 0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(1));
    add("perr_hold2", 0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(1));
    // Reset during a read issue: response dropped, request under reset ignored
    add("rst_iss",    0, 1, 12'o0600, 0, 0, 12'o0000, 12'o0000, e_ifu_iss(12'o0600, 1));
    add("rst_apply",  1, 1, 12'o0600, 0, 0, 12'o0000, 12'o0000, e_none(0));
    add("rst_regnt",  0, 1, 12'o0600, 0, 0, 12'o0000, 12'o0000, e_ifu_iss(12'o0600, 0));
    add("rst_vld",    0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_ifu_vld(12'o7002, 0));
    add("rst_idle",   0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(0));
    // Starvation guard: 4 EXU writes, then IFU, then the rest
    add("stv_w0",     0, 1, 12'o0700, 0, 1, 12'o0010, 12'o0001, e_exu_wr(12'o0010, 12'o0001, 0));
    add("stv_w1",     0, 1, 12'o0700, 0, 1, 12'o0011, 12'o0002, e_exu_wr(12'o0011, 12'o0002, 0));
    add("stv_w2",     0, 1, 12'o0700, 0, 1, 12'o0012, 12'o0003, e_exu_wr(12'o0012, 12'o0003, 0));
    add("stv_w3",     0, 1, 12'o0700, 0, 1, 12'o0013, 12'o0004, e_exu_wr(12'o0013, 12'o0004, 0));
    add("stv_ifu",    0, 1, 12'o0700, 0, 1, 12'o0014, 12'o0005, e_ifu_iss(12'o0700, 0));
    add("stv_ifuvld", 0, 0, 12'o0000, 0, 1, 12'o0014, 12'o0005, e_ifu_vld(12'o7102, 0));
    add("stv_w4",     0, 0, 12'o0000, 0, 1, 12'o0014, 12'o0005, e_exu_wr(12'o0014, 12'o0005, 0));
    add("stv_w5",     0, 0, 12'o0000, 0, 1, 12'o0015, 12'o0006, e_exu_wr(12'o0015, 12'o0006, 0));
    add("stv_idle",   0, 0, 12'o0000, 0, 0, 12'o0000, 12'o0000, e_none(0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; ifu_rd_req = vecs[i].ifu_req; ifu_rd_addr = vecs[i].ifu_addr;
      exu_rd_req = vecs[i].exu_rd; exu_wr_req = vecs[i].exu_wr;
      exu_addr = vecs[i].exu_addr; exu_wr_data = vecs[i].exu_wd;
      @(negedge clk);
      check(vecs[i].name, vecs[i].exp);
    end

    // Randomized phase against the reference model.
    rst = 1; ifu_rd_req = 0; exu_rd_req = 0; exu_wr_req = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (c >= 2) check("rand", model_exp());
      rst = (c < 2) || ($urandom_range(0, 99) < 2);
      if (!ifu_rd_req || ifu_gnt) begin
        if ($urandom_range(0, 99) < 50) begin
          ifu_rd_req = 1; ifu_rd_addr = 12'($urandom);
        end else begin
          ifu_rd_req = 0;
        end
      end
      if (!(exu_rd_req || exu_wr_req) || exu_gnt) begin
        int r;
        r = $urandom_range(0, 99);
        exu_rd_req  = (r < 35) || (r >= 70 && r < 73);
        exu_wr_req  = (r >= 35 && r < 73);
        exu_addr    = 12'($urandom);
        exu_wr_data = 12'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
